palette_sprite_layer: RTL and testbench
=======================================

// Module: palette_sprite_layer
// PURPOSE
// Parametrised successor to the single full-screen palettized sprite painter. Draws one positioned,
// integer-upscaled palette sprite on the VGA raster, with a writable colour palette, a transparent
// index, a background colour and a frame-synchronous brightness fade. Sits between the VGA controller
// (DrawX/DrawY/blank) and the top-level colour mux; the sprite ROM is external, synchronous, on vga_clk.
// PARAMETERS
// SPR_W      64   sprite width in ROM pixels
// SPR_H      64   sprite height in ROM pixels
// ADDR_W     12   ROM address width; must satisfy 2**ADDR_W >= SPR_W*SPR_H
// IDX_W      4    palette index width (2**IDX_W palette entries)
// SCALE_LOG2 0    upscale factor 2**SCALE_LOG2 in both axes (0..3)
// TRANS_IDX  0    palette index treated as transparent
// FADE_DIV   4    frames per brightness step during a fade (>=1)
// PORTS
// vga_clk     in   1       pixel clock; all logic posedge
// reset       in   1       synchronous, active-high
// DrawX       in   10      current pixel column (0..639 visible)
// DrawY       in   10      current pixel row (0..479 visible)
// blank       in   1       1 = visible region (active-high display enable)
// pos_x       in   10      requested sprite left edge, screen pixels
// pos_y       in   10      requested sprite top edge, screen pixels
// bg_rgb      in   12      background colour {r,g,b} for transparent/outside pixels
// pal_we      in   1       palette write strobe
// pal_waddr   in   IDX_W   palette entry to write
// pal_wdata   in   12      palette {r,g,b} write data
// fade_start  in   1       pulse: begin fade-out (1) from full brightness
// fade_in     in   1       pulse: begin fade-in toward full brightness
// rom_addr    out  ADDR_W  sprite ROM read address (registered)
// rom_q       in   IDX_W   sprite ROM data, valid 1 cycle after rom_addr
// red,green,blue out 4 each final pixel colour (registered)
// fade_busy   out  1       1 while brightness is stepping
// BEHAVIOUR
// - Position latch: pos_x/pos_y sampled into act_x/act_y only on frame start (DrawX==0 && DrawY==0);
//   never mid-frame, so no tearing. Reset: act_x=act_y=0.
// - Window: in_win = DrawX-act_x in [0, SPR_W<<SCALE_LOG2) and DrawY-act_y likewise; 11-bit
//   unsigned subtraction, negative difference => outside. Sprite clipped at screen edges, no wrap.
// - Address: u=(DrawX-act_x)>>SCALE_LOG2, v=(DrawY-act_y)>>SCALE_LOG2, rom_addr=v*SPR_W+u.
//   Outside the window rom_addr holds 0.
// - Pipeline, 3 cycles DrawX/DrawY -> colour:
//   S1: register rom_addr, in_win, blank. S2: rom_q valid; palette read (combinational on rom_q);
//   register colour sel, in_win, blank. S3: apply brightness; register red/green/blue.
// - Colour select: !blank -> 0x000; blank && (!in_win || rom_q==TRANS_IDX) -> bg_rgb;
//   else palette[rom_q]. Brightness applied to sprite and background alike, not to blanking.
// - Brightness: 5-bit bright in 0..16; channel_out = (c*bright)>>4, 8-bit product, 16 -> identity.
// - Fade FSM: IDLE, FADE_OUT, FADE_IN. Frame counter 0..FADE_DIV-1 advances on each frame start
//   while not IDLE; on wrap bright steps by 1. FADE_OUT ends in IDLE at bright=0 (held dark);
//   FADE_IN ends in IDLE at bright=16. fade_start/fade_in in IDLE only; ignored otherwise, except
//   fade_in in FADE_OUT reverses direction from current bright. Both same cycle -> fade_start wins.
//   fade_busy = (state != IDLE).
// - Palette: 2**IDX_W x 12 regs; write on posedge when pal_we. Write to entry being read same cycle
//   -> read returns old value. Reset: entry i = {i,i,i} truncated to 4 bits (grey ramp).
// - Reset: red/green/blue=0, rom_addr=0, pipeline flags 0, bright=16, state IDLE, frame counter 0.
//   Reset mid-frame: outputs 0 for 3 cycles after deassert, then normal; position relatched next frame.
// TESTING
// - pos=(100,50), SCALE_LOG2=0, ROM idx=i at addr i: DrawX=100,DrawY=50 -> rom_addr=0; DrawX=163 ->
//   rom_addr=63; DrawX=164 -> bg_rgb; colour appears exactly 3 cycles after coordinates.
// - SCALE_LOG2=1, pos=(0,0): DrawX=0..1 -> rom_addr 0; DrawX=2 -> 1; DrawY=2,DrawX=0 -> rom_addr=SPR_W.
// - pos_x changed 100->200 mid-frame -> window stays at 100 until DrawX=0,DrawY=0, then 200.
// - pos=(600,450): sprite clipped; DrawX=639 -> rom_addr=39 on row 450; no wrap to column 0.
// - pal write entry 3 = 0xF80, pixel idx 3 -> 0xF80; idx TRANS_IDX -> bg_rgb; blank=0 -> 0x000.
// - FADE_DIV=4, fade_start: bright 16->15 after 4 frames, 0 after 64 frames, fade_busy drops;
//   palette 0xFFF at bright 8 -> 0x777; fade_in mid-fade reverses; reset mid-fade -> bright=16, IDLE.

Source files
------------

// File: rtl/palette_sprite_layer.sv
// Positioned, integer-upscaled palette sprite layer for the VGA raster.
// The layer latches the sprite position once per frame and fetches pixel indices from an
// external synchronous ROM. Each index is resolved through a writable palette, or replaced
// by the background colour when the pixel is transparent. A frame-locked brightness fade is
// applied before the registered RGB output. Coordinates reach the RGB output 3 clocks later.
module palette_sprite_layer #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int IDX_W      = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int TRANS_IDX  = 0,
  parameter int FADE_DIV   = 4
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [11:0]       bg_rgb,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_waddr,
  input  logic [11:0]       pal_wdata,
  input  logic              fade_start,
  input  logic              fade_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              fade_busy
);

  localparam int WIN_W = SPR_W << SCALE_LOG2;
  localparam int WIN_H = SPR_H << SCALE_LOG2;
  localparam int PAL_N = 2 ** IDX_W;
  localparam int CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;

  // Brightness scaling of one 4-bit channel; bright=16 is the identity.
  function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [4:0] b);
    logic [7:0] p;
    p = {4'd0, c} * {3'd0, b};
    return 4'(p >> 4);
  endfunction

  logic              frame_start;
  logic [9:0]        act_x, act_y;
  logic [9:0]        eff_x, eff_y;
  logic [10:0]       dx, dy;
  logic              in_win;
  logic [9:0]        u, v;
  logic [ADDR_W-1:0] addr_c;

  logic              win_p1, vld_p1;
  logic              win_p2, vld_p2;

  logic [11:0]       pal [PAL_N];
  logic [11:0]       sel_rgb;

  fade_state_t       state;
  logic [4:0]        bright;
  logic [CNT_W-1:0]  fcnt;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  // The frame-start pixel already uses the newly requested position.
  assign eff_x = frame_start ? pos_x : act_x;
  assign eff_y = frame_start ? pos_y : act_y;

  // A borrow into bit 10 means the pixel lies left of or above the sprite.
  assign dx = {1'b0, DrawX} - {1'b0, eff_x};
  assign dy = {1'b0, DrawY} - {1'b0, eff_y};

  assign in_win = !dx[10] && !dy[10] &&
                  ({22'd0, dx[9:0]} < 32'(WIN_W)) &&
                  ({22'd0, dy[9:0]} < 32'(WIN_H));

  assign u      = dx[9:0] >> SCALE_LOG2;
  assign v      = dy[9:0] >> SCALE_LOG2;
  assign addr_c = ADDR_W'(v) * ADDR_W'(SPR_W) + ADDR_W'(u);

  // Latch the sprite position only at frame start so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      act_x <= '0;
      act_y <= '0;
    end else if (frame_start) begin
      act_x <= pos_x;
      act_y <= pos_y;
    end
  end

  // ---- stage 1: ROM address, window and display-enable flags ----
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr <= '0;
      win_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      rom_addr <= in_win ? addr_c : '0;
      win_p1   <= in_win;
      vld_p1   <= blank;
    end
  end

  // ---- stage 2: flags aligned with rom_q, which the ROM returns this cycle ----
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      win_p2 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      win_p2 <= win_p1;
      vld_p2 <= vld_p1;
    end
  end

  // Palette registers; a write lands at the edge, so a same-cycle read sees the old entry.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= {3{4'(i)}};
    end else if (pal_we) begin
      pal[pal_waddr] <= pal_wdata;
    end
  end

  // Colour select: blanking, background/transparent, or palette lookup on rom_q.
  always_comb begin
    sel_rgb = 12'h000;
    if (vld_p2) begin
      if (!win_p2 || (rom_q == IDX_W'(TRANS_IDX))) sel_rgb = bg_rgb;
      else                                         sel_rgb = pal[rom_q];
    end
  end

  // ---- stage 3: brightness applied, RGB registered ----
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else begin
      red   <= scale_ch(sel_rgb[11:8], bright);
      green <= scale_ch(sel_rgb[7:4],  bright);
      blue  <= scale_ch(sel_rgb[3:0],  bright);
    end
  end

  // Fade FSM: one brightness step every FADE_DIV frame starts while fading.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state  <= IDLE;
      bright <= 5'd16;
      fcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fade_start) begin
            state  <= FADE_OUT;
            bright <= 5'd16;
            fcnt   <= '0;
          end else if (fade_in && (bright != 5'd16)) begin
            state <= FADE_IN;
            fcnt  <= '0;
          end
        end
        FADE_OUT: begin
          if (fade_in && !fade_start) begin
            state <= (bright == 5'd16) ? IDLE : FADE_IN;
            fcnt  <= '0;
          end else if (frame_start) begin
            if (fcnt == CNT_W'(FADE_DIV - 1)) begin
              fcnt   <= '0;
              bright <= bright - 5'd1;
              if (bright == 5'd1) state <= IDLE;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        FADE_IN: begin
          if (frame_start) begin
            if (fcnt == CNT_W'(FADE_DIV - 1)) begin
              fcnt   <= '0;
              bright <= bright + 5'd1;
              if (bright == 5'd15) state <= IDLE;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fade_busy = (state != IDLE);

endmodule

// File: tb/tb_palette_sprite_layer.sv
// Bench for palette_sprite_layer: an unscaled and a 2x-scaled instance share the raster inputs,
// each with its own synchronous ROM model holding index = address[3:0].
module tb_palette_sprite_layer;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [9:0]  pos_x, pos_y;
  logic [11:0] bg_rgb;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        fade_start, fade_in;

  logic [11:0] rom_addr0, rom_addr1;
  logic [3:0]  rom_q0, rom_q1;
  logic [3:0]  red0, green0, blue0, red1, green1, blue1;
  logic        fade_busy0, fade_busy1;

  logic [3:0]  rom_mem [4096];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [11:0] v;
    int          due;
  } ent_t;

  ent_t qc[$];
  ent_t qa[$];
  ent_t qb[$];

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  always @(posedge vga_clk) begin
    rom_q0 <= rom_mem[rom_addr0];
    rom_q1 <= rom_mem[rom_addr1];
  end

  palette_sprite_layer #(.SPR_W(64), .SPR_H(64), .ADDR_W(12), .IDX_W(4), .SCALE_LOG2(0),
                         .TRANS_IDX(0), .FADE_DIV(4)) u0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .bg_rgb(bg_rgb), .pal_we(pal_we), .pal_waddr(pal_waddr),
    .pal_wdata(pal_wdata), .fade_start(fade_start), .fade_in(fade_in), .rom_addr(rom_addr0),
    .rom_q(rom_q0), .red(red0), .green(green0), .blue(blue0), .fade_busy(fade_busy0));

  palette_sprite_layer #(.SPR_W(64), .SPR_H(64), .ADDR_W(12), .IDX_W(4), .SCALE_LOG2(1),
                         .TRANS_IDX(0), .FADE_DIV(4)) u1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .bg_rgb(bg_rgb), .pal_we(pal_we), .pal_waddr(pal_waddr),
    .pal_wdata(pal_wdata), .fade_start(fade_start), .fade_in(fade_in), .rom_addr(rom_addr1),
    .rom_q(rom_q1), .red(red1), .green(green1), .blue(blue1), .fade_busy(fade_busy1));

  // One raster cycle. Expectations (-1 = none) are queued with the cycle at which the DUT
  // output is due: rom_addr one edge later, RGB three edges later. Due entries are popped
  // and compared just after the edge.
  task automatic step(input string nm, input int x, input int y, input logic bl,
                      input int er, input int ea, input int eb);
    ent_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    e.nm = nm;
    if (er >= 0) begin e.v = 12'(er); e.due = cyc + 3; qc.push_back(e); end
    if (ea >= 0) begin e.v = 12'(ea); e.due = cyc + 1; qa.push_back(e); end
    if (eb >= 0) begin e.v = 12'(eb); e.due = cyc + 1; qb.push_back(e); end
    @(posedge vga_clk);
    #1;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      e = qa.pop_front();
      n_tests++;
      if (rom_addr0 !== e.v) begin
        n_fail++;
        $display("FAIL %s rom_addr(scale1x) got %0d expected %0d", e.nm, rom_addr0, e.v);
      end
    end
    while (qb.size() > 0 && qb[0].due <= cyc) begin
      e = qb.pop_front();
      n_tests++;
      if (rom_addr1 !== e.v) begin
        n_fail++;
        $display("FAIL %s rom_addr(scale2x) got %0d expected %0d", e.nm, rom_addr1, e.v);
      end
    end
    while (qc.size() > 0 && qc[0].due <= cyc) begin
      e = qc.pop_front();
      n_tests++;
      if ({red0, green0, blue0} !== e.v) begin
        n_fail++;
        $display("FAIL %s rgb got %h expected %h", e.nm, {red0, green0, blue0}, e.v);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 700, 0, 1'b0, -1, -1, -1);
  endtask

  task automatic frame();
    step("frame", 0, 0, 1'b0, -1, -1, -1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("rst_out", 50, 50, 1'b1, 0, 0, 0);
    n_tests++;
    if (fade_busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fade_busy got %b expected 0", fade_busy0);
    end
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_window();
    pos_x = 10'd100; pos_y = 10'd50;
    frame();
    step("win_topleft",   100,  50, 1'b1, 'h123,    0, -1);
    step("win_second",    101,  50, 1'b1, 'h111,    1, -1);
    step("win_right",     163,  50, 1'b1, 'hFFF,   63, -1);
    step("win_right_out", 164,  50, 1'b1, 'h123,    0, -1);
    step("win_left_out",   99,  50, 1'b1, 'h123,    0, -1);
    step("win_mid",       110,  51, 1'b1, 'hAAA,   74, -1);
    step("win_top_out",   100,  49, 1'b1, 'h123,    0, -1);
    step("win_blank",     120,  60, 1'b0, 'h000,  660, -1);
    step("win_bottom",    100, 113, 1'b1, 'h123, 4032, -1);
    step("win_bot_out",   100, 114, 1'b1, 'h123,    0, -1);
    idle(3);
  endtask

  task automatic test_scale();
    pos_x = 10'd0; pos_y = 10'd0;
    step("sc_origin", 0, 0, 1'b1, 'h123,   0,  0);
    step("sc_x1",     1, 0, 1'b1, -1,      1,  0);
    step("sc_x2",     2, 0, 1'b1, 'h222,   2,  1);
    step("sc_x3",     3, 0, 1'b1, -1,      3,  1);
    step("sc_y2",     0, 2, 1'b1, -1,    128, 64);
    step("sc_y1",     0, 1, 1'b1, -1,     64,  0);
    step("sc_x127", 127, 0, 1'b1, -1,      0, 63);
    step("sc_x128", 128, 0, 1'b1, -1,      0,  0);
    idle(3);
  endtask

  task automatic test_pos_latch();
    pos_x = 10'd100; pos_y = 10'd0;
    frame();
    pos_x = 10'd200;
    step("pl_old_in",   105, 0, 1'b1, 'h555, 5, -1);
    step("pl_new_out",  205, 0, 1'b1, 'h123, 0, -1);
    frame();
    step("pl_new_in",   205, 0, 1'b1, 'h555, 5, -1);
    step("pl_old_out",  105, 0, 1'b1, 'h123, 0, -1);
    idle(3);
  endtask

  task automatic test_clip();
    pos_x = 10'd600; pos_y = 10'd450;
    frame();
    step("clip_edge",    639, 450, 1'b1, 'h777, 39, 19);
    step("clip_in",      601, 451, 1'b1, 'h111, 65,  0);
    step("clip_nowrap",    0, 450, 1'b1, 'h123,  0,  0);
    step("clip_nowrap2",   5, 451, 1'b1, 'h123,  0,  0);
    idle(3);
  endtask

  task automatic test_palette();
    pal_we = 1'b1; pal_waddr = 4'd3; pal_wdata = 12'hF80;
    idle(1);
    pal_we = 1'b0;
    step("pal_hit",   603, 450, 1'b1, 'hF80, 3, -1);
    step("pal_trans", 600, 450, 1'b1, 'h123, 0, -1);
    step("pal_blank", 603, 450, 1'b0, 'h000, 3, -1);
    step("pal_old",   605, 450, 1'b1, 'h555, 5, -1);
    idle(1);
    pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 12'h0F0;
    idle(1);
    pal_we = 1'b0;
    step("pal_new",   605, 450, 1'b1, 'h0F0, 5, -1);
    idle(3);
  endtask

  task automatic test_fade();
    int ep, eg;
    fade_start = 1'b1;
    idle(1);
    fade_start = 1'b0;
    n_tests++;
    if (fade_busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL fade_busy_start got %b expected 1", fade_busy0);
    end
    for (int f = 1; f <= 64; f++) begin
      frame();
      if (f == 63 || f == 64) begin
        n_tests++;
        if (fade_busy0 !== (f == 63)) begin
          n_fail++;
          $display("FAIL fade_busy_f%0d got %b expected %b", f, fade_busy0, (f == 63));
        end
      end
      ep = -1; eg = -1;
      case (f)
        3:  begin ep = 'hFFF; eg = 'h123; end
        4:  begin ep = 'hEEE; eg = 'h012; end
        32: begin ep = 'h777; eg = 'h011; end
        64: begin ep = 'h000; eg = 'h000; end
        default: ;
      endcase
      if (ep >= 0) begin
        step("fade_pix", 615, 450, 1'b1, ep, -1, -1);
        step("fade_bg",    0, 100, 1'b1, eg, -1, -1);
        idle(3);
      end
    end
  endtask

  task automatic test_fade_reverse();
    fade_start = 1'b1;
    idle(1);
    fade_start = 1'b0;
    for (int f = 0; f < 8; f++) frame();
    step("rev_b14", 615, 450, 1'b1, 'hDDD, -1, -1);
    idle(3);
    fade_in = 1'b1;
    idle(1);
    fade_in = 1'b0;
    for (int f = 0; f < 4; f++) frame();
    n_tests++;
    if (fade_busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_busy_b15 got %b expected 1", fade_busy0);
    end
    step("rev_b15", 615, 450, 1'b1, 'hEEE, -1, -1);
    idle(3);
    for (int f = 0; f < 4; f++) frame();
    n_tests++;
    if (fade_busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_busy_b16 got %b expected 0", fade_busy0);
    end
    step("rev_b16", 615, 450, 1'b1, 'hFFF, -1, -1);
    idle(3);
  endtask

  task automatic test_reset_mid_fade();
    fade_start = 1'b1;
    idle(1);
    fade_start = 1'b0;
    for (int f = 0; f < 8; f++) frame();
    reset = 1'b1;
    step("rmf_rst0", 615, 450, 1'b1, 0, 0, -1);
    step("rmf_rst1", 615, 450, 1'b1, 0, 0, -1);
    reset = 1'b0;
    n_tests++;
    if (fade_busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rmf_busy got %b expected 0", fade_busy0);
    end
    step("rmf_pix5", 5, 5, 1'b1, 'h555, 325, 130);
    step("rmf_pix3", 3, 0, 1'b1, 'h333,   3,   1);
    idle(4);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom_mem[a] = 4'(a);
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
    pos_x = '0; pos_y = '0; bg_rgb = 12'h123;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    fade_start = 1'b0; fade_in = 1'b0;

    test_reset();
    test_window();
    test_scale();
    test_pos_latch();
    test_clip();
    test_palette();
    test_fade();
    test_fade_reverse();
    test_reset_mid_fade();

    n_tests++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d pending expected 0", qa.size() + qb.size() + qc.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
